// File: rtl/fht_butterfly.sv
// fht_butterfly: two-point radix-2 butterfly for the fast Hartley transform.
//
//   m    = round((cos*x1 + sin*x2) / W_MAX)        (stage 1, register ROUND_SUM_MUL)
//   oY_0 = round((x0 + m) / 2)                      (stage 2, registered)
//   oY_1 = round((x0 - m) / 2)                      (stage 2, registered)
//
// Rounding is round-half-up (add half, arithmetic shift right).
// x1, x2 and the twiddle pair enter one cycle before the matching x0.
//
// Build option:
//   FHT_BUT_SAT_EN defined   -> stage-2 results saturate to [-MAX_D, MAX_D-1]
//   FHT_BUT_SAT_EN undefined -> stage-2 results keep their low D_BIT bits (wrap)
//
// Reset iRESET is synchronous and active-high. It clears ROUND_SUM_MUL, oY_0
// and oY_1, so any samples in flight are discarded.

module fht_butterfly #(
   parameter int D_BIT      = 16,
   parameter int W_BIT      = 16,
   parameter int HALF_W_MAX = 2 ** (W_BIT - 3)
) (
   input  logic                    iCLK,
   input  logic                    iRESET,
   input  logic signed [D_BIT-1:0] iX_0,
   input  logic signed [D_BIT-1:0] iX_1,
   input  logic signed [D_BIT-1:0] iX_2,
   input  logic signed [W_BIT-1:0] iSIN,
   input  logic signed [W_BIT-1:0] iCOS,
   output logic signed [D_BIT-1:0] oY_0,
   output logic signed [D_BIT-1:0] oY_1
);

   // Word widths along the datapath.
   localparam int P_BIT = D_BIT + W_BIT;     // one product
   localparam int S_BIT = P_BIT + 1;         // sum of two products, cannot overflow
   localparam int M_BIT = D_BIT + 2;         // rotated value, |m| <= sqrt(2)*MAX_D
   localparam int A_BIT = D_BIT + 3;         // x0 +/- m, with headroom for the +1
   localparam int SHIFT = W_BIT - 2;         // divide by W_MAX

   // Rounding constants, kept signed so the shifts stay arithmetic.
   localparam logic signed [S_BIT-1:0] ROUND_K = S_BIT'(HALF_W_MAX);
   localparam logic signed [A_BIT-1:0] A_ONE   = {{(A_BIT-1){1'b0}}, 1'b1};

   // Output range limits, expressed in the stage-2 width.
   localparam logic signed [A_BIT-1:0] A_HI = {{(A_BIT-D_BIT+1){1'b0}}, {(D_BIT-1){1'b1}}};
   localparam logic signed [A_BIT-1:0] A_LO = {{(A_BIT-D_BIT+1){1'b1}}, {(D_BIT-1){1'b0}}};
   localparam logic signed [D_BIT-1:0] D_HI = {1'b0, {(D_BIT-1){1'b1}}};
   localparam logic signed [D_BIT-1:0] D_LO = {1'b1, {(D_BIT-1){1'b0}}};

   // Divide the product sum by W_MAX with round-half-up. The result always fits
   // M_BIT because the twiddle pair lies on the unit circle.
   function automatic logic signed [M_BIT-1:0] round_to_unit(
      input logic signed [S_BIT-1:0] sum_v
   );
      logic signed [S_BIT-1:0] shifted_v;
      shifted_v = (sum_v + ROUND_K) >>> SHIFT;
      return M_BIT'(shifted_v);
   endfunction

   // Halve with round-half-up; the result keeps the stage-2 width.
   function automatic logic signed [A_BIT-1:0] halve_round(
      input logic signed [A_BIT-1:0] val_v
   );
      return (val_v + A_ONE) >>> 1;
   endfunction

   // Bring a halved stage-2 value back to the output word width.
   function automatic logic signed [D_BIT-1:0] fit_word(
      input logic signed [A_BIT-1:0] val_v
   );
      logic signed [D_BIT-1:0] res_v;
`ifdef FHT_BUT_SAT_EN
      if (val_v > A_HI) begin
         res_v = D_HI;
      end else if (val_v < A_LO) begin
         res_v = D_LO;
      end else begin
         res_v = D_BIT'(val_v);
      end
`else
      // Wrap: only the low bits are kept. The range limits are unused here.
      res_v = D_BIT'(val_v);
`endif
      return res_v;
   endfunction

   // Stage-1 signals
   logic signed [P_BIT-1:0] p1_s;
   logic signed [P_BIT-1:0] p2_s;
   logic signed [S_BIT-1:0] sum_s;
   logic signed [M_BIT-1:0] m_s;

   // Stage-1 register: the rotated, rounded value m
   logic signed [M_BIT-1:0] ROUND_SUM_MUL;

   // Stage-2 signals
   logic signed [A_BIT-1:0] a_s;
   logic signed [A_BIT-1:0] b_s;
   logic signed [A_BIT-1:0] a_half_s;
   logic signed [A_BIT-1:0] b_half_s;
   logic signed [D_BIT-1:0] y0_s;
   logic signed [D_BIT-1:0] y1_s;

   // Stage 1: rotate (x1, x2) by the twiddle pair and scale back to data units.
   always_comb begin
      p1_s  = P_BIT'(iCOS) * P_BIT'(iX_1);
      p2_s  = P_BIT'(iSIN) * P_BIT'(iX_2);
      sum_s = S_BIT'(p1_s) + S_BIT'(p2_s);
      m_s   = round_to_unit(sum_s);
   end

   // Stage-1 register, cleared by reset.
   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         ROUND_SUM_MUL <= {M_BIT{1'b0}};
      end else begin
         ROUND_SUM_MUL <= m_s;
      end
   end

   // Stage 2: butterfly add/subtract against x0, halve, then fit to D_BIT.
   always_comb begin
      a_s      = A_BIT'(iX_0) + A_BIT'(ROUND_SUM_MUL);
      b_s      = A_BIT'(iX_0) - A_BIT'(ROUND_SUM_MUL);
      a_half_s = halve_round(a_s);
      b_half_s = halve_round(b_s);
      y0_s     = fit_word(a_half_s);
      y1_s     = fit_word(b_half_s);
   end

   // Output registers, cleared by reset.
   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         oY_0 <= {D_BIT{1'b0}};
         oY_1 <= {D_BIT{1'b0}};
      end else begin
         oY_0 <= y0_s;
         oY_1 <= y1_s;
      end
   end

endmodule

// File: tb/tb_fht_butterfly.sv
// Self-checking bench for fht_butterfly.
// The reference model works with plain integer arithmetic: floor division for
// the round-half-up steps, then clamp or modular wrap. The real-valued result is
// checked to within 1 LSB wherever the output does not overflow.
// Honours FHT_BUT_SAT_EN in the same way as the design.

module tb_fht_butterfly;

   localparam int     D_BIT = 16;
   localparam int     W_BIT = 16;
   localparam longint W_MAX = 64'sd1 << (W_BIT - 2);
   localparam longint HALF  = W_MAX / 2;
   localparam longint MAX_D = 64'sd1 << (D_BIT - 1);

   logic                    iCLK = 1'b0;
   logic                    iRESET;
   logic signed [D_BIT-1:0] iX_0, iX_1, iX_2;
   logic signed [W_BIT-1:0] iSIN, iCOS;
   logic signed [D_BIT-1:0] oY_0, oY_1;

   int total = 0;
   int bad   = 0;

   // Model state: the previous set's rotated value and its raw inputs.
   longint m_prev  = 0;
   longint px1     = 0;
   longint px2     = 0;
   longint ps      = 0;
   longint pc      = 0;

   fht_butterfly #(
      .D_BIT(D_BIT),
      .W_BIT(W_BIT),
      .HALF_W_MAX(int'(HALF))
   ) dut (
      .iCLK  (iCLK),
      .iRESET(iRESET),
      .iX_0  (iX_0),
      .iX_1  (iX_1),
      .iX_2  (iX_2),
      .iSIN  (iSIN),
      .iCOS  (iCOS),
      .oY_0  (oY_0),
      .oY_1  (oY_1)
   );

   always #5 iCLK = ~iCLK;

   function automatic longint floor_div(input longint n, input longint d);
      longint q;
      q = n / d;
      if ((n % d != 0) && (n < 0)) q = q - 1;
      return q;
   endfunction

   function automatic longint ref_m(input longint x1, input longint x2,
                                    input longint s, input longint c);
      return floor_div(c * x1 + s * x2 + HALF, W_MAX);
   endfunction

   // Halved value before it is fitted to the output range.
   function automatic longint ref_raw(input longint x0, input longint mv);
      return floor_div(x0 + mv + 1, 2);
   endfunction

   function automatic bit ref_ovf(input longint v);
      return (v > MAX_D - 1) || (v < -MAX_D);
   endfunction

   function automatic longint ref_y(input longint x0, input longint mv);
      longint v;
      v = ref_raw(x0, mv);
`ifdef FHT_BUT_SAT_EN
      if (v > MAX_D - 1) v = MAX_D - 1;
      if (v < -MAX_D)    v = -MAX_D;
`else
      v = v - floor_div(v + MAX_D, 2 * MAX_D) * (2 * MAX_D);
`endif
      return v;
   endfunction

   function automatic longint round_real(input real r);
      if (r >= 0.0) return longint'($rtoi(r + 0.5));
      return -longint'($rtoi(-r + 0.5));
   endfunction

   function automatic real abs_real(input real r);
      return (r < 0.0) ? -r : r;
   endfunction

   task automatic check(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_acc(input string tag, input longint obs, input real exact);
      total++;
      assert (abs_real(real'(obs) - exact) < 1.0) else begin
         bad++;
         $error("FAIL %s: got %0d, expected %f within 1 LSB", tag, obs, exact);
      end
   endtask

   // One clock: drive a new (x1, x2, sin, cos) set plus x0 for the previous set,
   // then compare ROUND_SUM_MUL and both outputs against the model.
   task automatic apply(input longint x1, input longint x2, input longint s,
                        input longint c, input longint x0, input bit rst,
                        input bit acc);
      longint em, ey0, ey1;
      real    rot, ex0, ex1;
      iX_1   = D_BIT'(x1);
      iX_2   = D_BIT'(x2);
      iSIN   = W_BIT'(s);
      iCOS   = W_BIT'(c);
      iX_0   = D_BIT'(x0);
      iRESET = rst;
      @(posedge iCLK);
      #1;
      if (rst) begin
         em  = 0;
         ey0 = 0;
         ey1 = 0;
      end else begin
         em  = ref_m(x1, x2, s, c);
         ey0 = ref_y(x0, m_prev);
         ey1 = ref_y(x0, -m_prev);
      end
      check("round_sum_mul", longint'(dut.ROUND_SUM_MUL), em);
      check("y0", longint'(oY_0), ey0);
      check("y1", longint'(oY_1), ey1);
      if (!rst && acc) begin
         rot = (real'(pc) * real'(px1) + real'(ps) * real'(px2)) / real'(W_MAX);
         ex0 = (real'(x0) + rot) / 2.0;
         ex1 = (real'(x0) - rot) / 2.0;
         if (!ref_ovf(ref_raw(x0, m_prev))) check_acc("y0_accuracy", longint'(oY_0), ex0);
         if (!ref_ovf(ref_raw(x0, -m_prev))) check_acc("y1_accuracy", longint'(oY_1), ex1);
      end
      m_prev = em;
      px1 = rst ? 0 : x1;
      px2 = rst ? 0 : x2;
      ps  = rst ? 0 : s;
      pc  = rst ? 0 : c;
   endtask

   task automatic random_step(input bit rst);
      longint x0, x1, x2, s, c;
      real    th;
      x0 = longint'($urandom_range(0, 65535)) - MAX_D;
      x1 = longint'($urandom_range(0, 65535)) - MAX_D;
      x2 = longint'($urandom_range(0, 65535)) - MAX_D;
      th = 6.283185307179586 * real'($urandom_range(0, 65535)) / 65536.0;
      c  = round_real(real'(W_MAX) * $cos(th));
      s  = round_real(real'(W_MAX) * $sin(th));
      apply(x1, x2, s, c, x0, rst, 1'b1);
   endtask

   initial begin
      iRESET = 1'b1;
      iX_0 = '0; iX_1 = '0; iX_2 = '0; iSIN = '0; iCOS = '0;

      // Reset state, with non-zero inputs that must be ignored.
      apply(0, 0, 0, 0, 0, 1'b1, 1'b0);
      apply(1000, -2000, 12288, 8000, 777, 1'b1, 1'b0);

      // Basic rounding
      apply(0, 2, 12288, 0, 0, 1'b0, 1'b0);
      check("basic_m", longint'(dut.ROUND_SUM_MUL), 2);
      apply(0, 0, 0, 0, 10, 1'b0, 1'b0);
      check("basic_y0", longint'(oY_0), 6);
      check("basic_y1", longint'(oY_1), 4);

      // Unit cosine
      apply(32767, 0, 0, 16384, 0, 1'b0, 1'b0);
      check("unit_m", longint'(dut.ROUND_SUM_MUL), 32767);
      apply(0, 0, 0, 0, 32767, 1'b0, 1'b0);
      check("unit_y0", longint'(oY_0), 32767);
      check("unit_y1", longint'(oY_1), 0);

      // Positive overflow at 45 degrees
      apply(32767, 32767, 11585, 11585, 0, 1'b0, 1'b0);
      check("pos45_m", longint'(dut.ROUND_SUM_MUL), 46339);
      apply(0, 0, 0, 0, 32767, 1'b0, 1'b0);
      check("pos45_y1", longint'(oY_1), -6786);
`ifdef FHT_BUT_SAT_EN
      check("pos45_y0", longint'(oY_0), 32767);
`else
      check("pos45_y0", longint'(oY_0), -25983);
`endif

      // Negative overflow at 45 degrees
      apply(-32768, -32768, 11585, 11585, 0, 1'b0, 1'b0);
      check("neg45_m", longint'(dut.ROUND_SUM_MUL), -46340);
      apply(0, 0, 0, 0, -32768, 1'b0, 1'b0);
      check("neg45_y1", longint'(oY_1), 6786);
`ifdef FHT_BUT_SAT_EN
      check("neg45_y0", longint'(oY_0), -32768);
`else
      check("neg45_y0", longint'(oY_0), 25982);
`endif

      // Reset mid-stream: in-flight data is dropped and the stream then resumes.
      for (int i = 0; i < 8; i++) random_step(1'b0);
      random_step(1'b1);
      check("midrst_m", longint'(dut.ROUND_SUM_MUL), 0);
      check("midrst_y0", longint'(oY_0), 0);
      check("midrst_y1", longint'(oY_1), 0);
      for (int i = 0; i < 8; i++) random_step(1'b0);

      // Random sweep on the unit circle
      for (int i = 0; i < 10000; i++) random_step(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
